rename_regfile: RTL and testbench
=================================

Name: rename_regfile

Overview:
- Architectural register file plus register alias state for the 4-wide out-of-order core.
- Sits directly downstream of the reorder buffer commit port: consumes its 4 commit write slots to update architectural registers and clear pending-writer tags.
- Upstream, the dispatch stage uses it to rename up to 4 instructions per cycle and read 8 source operands with busy/tag information.

Parameters:
- NREG, 16, number of architectural registers (4-bit index)
- DW, 16, data width
- TW, 4, ROB tag width (16-entry ROB, modulo-16 arithmetic)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- commit_we_flat  in  4  ROB commit write enables; slot i at bit 3-i
- commit_target_flat  in  16  destination register per commit slot
- commit_data_flat  in  64  write data per commit slot
- commit_writer_flat  in  16  ROB index that produced each commit
- disp_valid_flat  in  4  dispatch slot valid
- disp_has_dest_flat  in  4  slot writes a register
- disp_dest_flat  in  16  destination register per slot
- rob_head  in  4  ROB head at dispatch; tags allocated from here
- src_idx_flat  in  32  8 source indices; slot i sources at ports 2i, 2i+1
- src_value_flat  out  128  operand values
- src_busy_flat  out  8  operand pending (value not yet architectural)
- src_tag_flat  out  32  ROB tag of pending producer
- disp_tag_flat  out  16  ROB tag allocated to each dispatch slot

Behaviour:
- Flattening: element k of an N-element bus occupies bits [W*(N-1-k)+W-1 : W*(N-1-k)]; element 0 is in the MSBs.
- State: regs[NREG] (DW), busy[NREG], tag[NREG] (TW).
- Reset (async, rst_n=0): all regs, busy and tag = 0. All outputs are combinational from state and inputs, so during reset every src_value = 0 and src_busy = 0. Assertion mid-operation discards all pending tags immediately.
- Tag allocation (combinational):
  - disp_tag[i] = rob_head + (count of disp_valid[j], j<i), mod 16.
  - Invalid slots still output the computed value; the value is ignored.
- Commit (posedge):
  - For each slot with commit_we: regs[target] <= data.
  - If busy[target] and tag[target] == writer, clear busy.
  - Same target in multiple slots in one cycle: the highest slot index wins, for both data and the tag match.
- Register 0 is hard-wired:
  - Writes to r0 are discarded; r0 never becomes busy.
  - Reads of r0 return value 0, busy 0, tag 0.
  - The ROB handles character output for target 0 itself.
- Rename (posedge):
  - For each slot with disp_valid & disp_has_dest & dest != 0: busy[dest] <= 1, tag[dest] <= disp_tag.
  - Same dest in multiple slots: the highest slot wins.
  - Rename and commit to the same register in one cycle: rename wins for busy/tag; commit still writes the data.
- Source read (combinational), priority highest first:
  1. Intra-group dependence: source of slot i equals dest of a valid, dest-writing slot j<i (dest != 0). Result: busy=1, tag=disp_tag[j] for the largest such j, value=regs[src].
  2. Commit bypass: a commit this cycle has target == src, register is busy, and tag matches. Result: busy=0, value=commit data (highest matching slot).
  3. State: value=regs, busy=busy, tag=tag.
- Readiness: sources of invalid slots are still evaluated; the output is don't-care.
- No backpressure: the dispatcher guarantees ROB space; this block always accepts.
- Tag wrap: comparisons are exact 4-bit equality. The 16-entry ROB makes stale-tag aliasing impossible while a producer is live.

Test Plan:
- Reset then read r5 → value 0, busy 0. Commit slot0 r5=0x1234 writer 3 → next cycle r5 reads 0x1234, busy 0.
- rob_head=14, disp_valid=1011, all dests r1/r2/r3 → disp_tags 14, -, 15, 0. Next cycle r1 busy tag 14, r3 busy tag 0.
- Dispatch slot0 dest r4, slot2 src r4 same cycle → slot2 source busy 1, tag = slot0 tag. Same test with slot0 invalid → busy from state (0).
- r6 busy tag 7. Commit r6 writer 5 → r6 still busy tag 7, data updated. Commit r6 writer 7 → busy 0. A same-cycle read of r6 returns committed data with busy 0.
- Same cycle: commit r2 writer 9 (matching), dispatch dest r2 tag 10 → r2 busy 1, tag 10, regs[r2] holds new data. Two commits to r8 (slot1=0xAAAA, slot3=0xBBBB) → r8=0xBBBB.
- Write to r0 via commit and dispatch → r0 reads 0, busy 0. Assert rst_n low mid-stream with r1..r4 busy → all clear immediately, asynchronously.

Source files
------------

// File: rtl/rename_regfile.sv
// Architectural register file with rename (busy/tag) state for a 4-wide dispatch group.
// Commits retire data and clear pending tags; dispatch allocates ROB tags and reads 8 operands.
module rename_regfile #(
  parameter int unsigned NREG = 16,
  parameter int unsigned DW   = 16,
  parameter int unsigned TW   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                commit_we_flat,
  input  logic [4*$clog2(NREG)-1:0] commit_target_flat,
  input  logic [4*DW-1:0]           commit_data_flat,
  input  logic [4*TW-1:0]           commit_writer_flat,
  input  logic [3:0]                disp_valid_flat,
  input  logic [3:0]                disp_has_dest_flat,
  input  logic [4*$clog2(NREG)-1:0] disp_dest_flat,
  input  logic [TW-1:0]             rob_head,
  input  logic [8*$clog2(NREG)-1:0] src_idx_flat,
  output logic [8*DW-1:0]           src_value_flat,
  output logic [7:0]                src_busy_flat,
  output logic [8*TW-1:0]           src_tag_flat,
  output logic [4*TW-1:0]           disp_tag_flat
);

  localparam int unsigned IW = $clog2(NREG);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [TW-1:0]   tag_q  [NREG];
  logic [TW-1:0]   tag_d  [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic          c_we   [4];
  logic [IW-1:0] c_tgt  [4];
  logic [DW-1:0] c_data [4];
  logic [TW-1:0] c_wr   [4];
  logic          d_wr   [4];
  logic [IW-1:0] d_dest [4];
  logic [TW-1:0] d_tag  [4];
  logic [IW-1:0] s_idx  [8];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c_we[k]   = commit_we_flat[3-k];
      c_tgt[k]  = commit_target_flat[IW*(3-k) +: IW];
      c_data[k] = commit_data_flat[DW*(3-k) +: DW];
      c_wr[k]   = commit_writer_flat[TW*(3-k) +: TW];
      d_dest[k] = disp_dest_flat[IW*(3-k) +: IW];
      d_wr[k]   = disp_valid_flat[3-k] && disp_has_dest_flat[3-k] && (d_dest[k] != '0);
    end
    for (int p = 0; p < 8; p++) begin
      s_idx[p] = src_idx_flat[IW*(7-p) +: IW];
    end
  end

  // Tags count only valid slots; dest-less slots still consume a ROB entry.
  always_comb begin
    logic [TW-1:0] acc;
    acc = rob_head;
    disp_tag_flat = '0;
    for (int i = 0; i < 4; i++) begin
      d_tag[i] = acc;
      disp_tag_flat[TW*(3-i) +: TW] = acc;
      if (disp_valid_flat[3-i]) acc = acc + TW'(1);
    end
  end

  always_comb begin
    logic [NREG-1:0] clr;
    clr = '0;
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      tag_d[r]  = tag_q[r];
    end
    // Ascending slot order lets the highest slot override both data and tag match.
    for (int c = 0; c < 4; c++) begin
      if (c_we[c] && c_tgt[c] != '0) begin
        regs_d[c_tgt[c]] = c_data[c];
        clr[c_tgt[c]]    = busy_q[c_tgt[c]] && (tag_q[c_tgt[c]] == c_wr[c]);
      end
    end
    busy_d = busy_q & ~clr;
    for (int i = 0; i < 4; i++) begin
      if (d_wr[i]) begin
        busy_d[d_dest[i]] = 1'b1;
        tag_d[d_dest[i]]  = d_tag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        tag_q[r]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
        tag_q[r]  <= tag_d[r];
      end
    end
  end

  always_comb begin
    logic [IW-1:0] s;
    logic [DW-1:0] val;
    logic          bsy;
    logic [TW-1:0] tg;
    src_value_flat = '0;
    src_busy_flat  = '0;
    src_tag_flat   = '0;
    for (int p = 0; p < 8; p++) begin
      s   = s_idx[p];
      val = regs_q[s];
      bsy = busy_q[s];
      tg  = tag_q[s];
      for (int c = 0; c < 4; c++) begin
        if (c_we[c] && c_tgt[c] == s && busy_q[s] && tag_q[s] == c_wr[c]) begin
          val = c_data[c];
          bsy = 1'b0;
        end
      end
      // Intra-group producer overrides everything; only earlier slots qualify.
      for (int j = 0; j < 4; j++) begin
        if (j < p / 2 && d_wr[j] && d_dest[j] == s) begin
          val = regs_q[s];
          bsy = 1'b1;
          tg  = d_tag[j];
        end
      end
      if (!rst_n || s == '0) begin
        val = '0;
        bsy = 1'b0;
        tg  = '0;
      end
      src_value_flat[DW*(7-p) +: DW] = val;
      src_busy_flat[7-p]             = bsy;
      src_tag_flat[TW*(7-p) +: TW]   = tg;
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed self-checking bench for rename_regfile: commit, rename, bypass, r0 and async reset.
module tb_rename_regfile;

  logic         clk;
  logic         rst_n;
  logic [3:0]   commit_we_flat;
  logic [15:0]  commit_target_flat;
  logic [63:0]  commit_data_flat;
  logic [15:0]  commit_writer_flat;
  logic [3:0]   disp_valid_flat;
  logic [3:0]   disp_has_dest_flat;
  logic [15:0]  disp_dest_flat;
  logic [3:0]   rob_head;
  logic [31:0]  src_idx_flat;
  logic [127:0] src_value_flat;
  logic [7:0]   src_busy_flat;
  logic [31:0]  src_tag_flat;
  logic [15:0]  disp_tag_flat;

  logic        cwe  [4];
  logic [3:0]  ctgt [4];
  logic [15:0] cdat [4];
  logic [3:0]  cwr  [4];
  logic        dv   [4];
  logic        dh   [4];
  logic [3:0]  dd   [4];
  logic [3:0]  sidx [8];

  int n_checks = 0;
  int n_pass   = 0;

  rename_regfile #(.NREG(16), .DW(16), .TW(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .commit_we_flat     (commit_we_flat),
    .commit_target_flat (commit_target_flat),
    .commit_data_flat   (commit_data_flat),
    .commit_writer_flat (commit_writer_flat),
    .disp_valid_flat    (disp_valid_flat),
    .disp_has_dest_flat (disp_has_dest_flat),
    .disp_dest_flat     (disp_dest_flat),
    .rob_head           (rob_head),
    .src_idx_flat       (src_idx_flat),
    .src_value_flat     (src_value_flat),
    .src_busy_flat      (src_busy_flat),
    .src_tag_flat       (src_tag_flat),
    .disp_tag_flat      (disp_tag_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      commit_we_flat[3-k]           = cwe[k];
      commit_target_flat[4*(3-k) +: 4] = ctgt[k];
      commit_data_flat[16*(3-k) +: 16] = cdat[k];
      commit_writer_flat[4*(3-k) +: 4] = cwr[k];
      disp_valid_flat[3-k]          = dv[k];
      disp_has_dest_flat[3-k]       = dh[k];
      disp_dest_flat[4*(3-k) +: 4]  = dd[k];
    end
    for (int p = 0; p < 8; p++) src_idx_flat[4*(7-p) +: 4] = sidx[p];
  end

  function automatic logic [15:0] sv(input int p);
    return src_value_flat[16*(7-p) +: 16];
  endfunction
  function automatic logic sb(input int p);
    return src_busy_flat[7-p];
  endfunction
  function automatic logic [3:0] st(input int p);
    return src_tag_flat[4*(7-p) +: 4];
  endfunction
  function automatic logic [3:0] dt(input int i);
    return disp_tag_flat[4*(3-i) +: 4];
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
  endtask

  task automatic clr_in();
    for (int k = 0; k < 4; k++) begin
      cwe[k] = 1'b0; ctgt[k] = '0; cdat[k] = '0; cwr[k] = '0;
      dv[k] = 1'b0; dh[k] = 1'b0; dd[k] = '0;
    end
    for (int p = 0; p < 8; p++) sidx[p] = '0;
    rob_head = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    sidx[0] = 4'd5;
    #3;
    check("rst_r5_val", sv(0), 0);
    check("rst_r5_busy", sb(0), 0);
    rst_n = 1'b1;
    tick();

    // Plain commit
    cwe[0] = 1'b1; ctgt[0] = 4'd5; cdat[0] = 16'h1234; cwr[0] = 4'd3;
    tick();
    clr_in();
    sidx[0] = 4'd5;
    #1;
    check("commit_r5_val", sv(0), 16'h1234);
    check("commit_r5_busy", sb(0), 0);

    // Tag allocation with wrap, slot1 invalid
    rob_head = 4'd14;
    dv[0] = 1'b1; dh[0] = 1'b1; dd[0] = 4'd1;
    dv[2] = 1'b1; dh[2] = 1'b1; dd[2] = 4'd2;
    dv[3] = 1'b1; dh[3] = 1'b1; dd[3] = 4'd3;
    #1;
    check("dtag0", dt(0), 14);
    check("dtag2", dt(2), 15);
    check("dtag3", dt(3), 0);
    tick();
    clr_in();
    sidx[0] = 4'd1; sidx[1] = 4'd3; sidx[2] = 4'd2;
    #1;
    check("r1_busy", sb(0), 1);
    check("r1_tag", st(0), 14);
    check("r3_busy", sb(1), 1);
    check("r3_tag", st(1), 0);
    check("r2_tag", st(2), 15);

    // Intra-group dependence
    rob_head = 4'd1;
    dv[0] = 1'b1; dh[0] = 1'b1; dd[0] = 4'd4;
    dv[2] = 1'b1;
    sidx[4] = 4'd4; sidx[1] = 4'd4;
    #1;
    check("intra_busy", sb(4), 1);
    check("intra_tag", st(4), 1);
    check("own_slot_src", sb(1), 0);
    dv[0] = 1'b0;
    #1;
    check("intra_invalid_busy", sb(4), 0);
    clr_in();

    // Tag-matched commit clearing and bypass
    rob_head = 4'd7; dv[0] = 1'b1; dh[0] = 1'b1; dd[0] = 4'd6;
    tick();
    clr_in();
    sidx[0] = 4'd6;
    #1;
    check("r6_busy", sb(0), 1);
    check("r6_tag", st(0), 7);
    cwe[0] = 1'b1; ctgt[0] = 4'd6; cdat[0] = 16'h0666; cwr[0] = 4'd5;
    #1;
    check("r6_nomatch_byp_busy", sb(0), 1);
    check("r6_nomatch_byp_val", sv(0), 0);
    tick();
    check("r6_stale_busy", sb(0), 1);
    check("r6_stale_tag", st(0), 7);
    check("r6_stale_val", sv(0), 16'h0666);
    cdat[0] = 16'h0777; cwr[0] = 4'd7;
    #1;
    check("r6_byp_val", sv(0), 16'h0777);
    check("r6_byp_busy", sb(0), 0);
    tick();
    clr_in();
    sidx[0] = 4'd6;
    #1;
    check("r6_clear_busy", sb(0), 0);
    check("r6_clear_val", sv(0), 16'h0777);

    // Same-dest rename: highest slot wins
    rob_head = 4'd3;
    dv[0] = 1'b1; dh[0] = 1'b1; dd[0] = 4'd10;
    dv[1] = 1'b1; dh[1] = 1'b1; dd[1] = 4'd10;
    dv[2] = 1'b1; dh[2] = 1'b1; dd[2] = 4'd9;
    tick();
    clr_in();
    sidx[0] = 4'd10; sidx[1] = 4'd9;
    #1;
    check("r10_tag", st(0), 4);
    check("r9_tag", st(1), 5);
    // Highest slot decides tag match: writer 6 does not match tag 5
    cwe[0] = 1'b1; ctgt[0] = 4'd9; cdat[0] = 16'h0901; cwr[0] = 4'd5;
    cwe[2] = 1'b1; ctgt[2] = 4'd9; cdat[2] = 16'h0902; cwr[2] = 4'd6;
    tick();
    clr_in();
    sidx[1] = 4'd9;
    #1;
    check("r9_multi_busy", sb(1), 1);
    check("r9_multi_val", sv(1), 16'h0902);

    // Rename beats commit on the same register
    rob_head = 4'd9; dv[0] = 1'b1; dh[0] = 1'b1; dd[0] = 4'd2;
    tick();
    cwe[0] = 1'b1; ctgt[0] = 4'd2; cdat[0] = 16'h2222; cwr[0] = 4'd9;
    rob_head = 4'd10;
    tick();
    clr_in();
    sidx[0] = 4'd2;
    #1;
    check("r2_busy", sb(0), 1);
    check("r2_tag", st(0), 10);
    check("r2_val", sv(0), 16'h2222);

    // Two commits to r8
    cwe[1] = 1'b1; ctgt[1] = 4'd8; cdat[1] = 16'hAAAA;
    cwe[3] = 1'b1; ctgt[3] = 4'd8; cdat[3] = 16'hBBBB;
    tick();
    clr_in();
    sidx[0] = 4'd8;
    #1;
    check("r8_val", sv(0), 16'hBBBB);

    // r0 is hard-wired
    cwe[0] = 1'b1; ctgt[0] = 4'd0; cdat[0] = 16'hFFFF;
    rob_head = 4'd4; dv[0] = 1'b1; dh[0] = 1'b1; dd[0] = 4'd0;
    dv[1] = 1'b1; sidx[2] = 4'd0;
    #1;
    check("r0_intra_busy", sb(2), 0);
    tick();
    clr_in();
    #1;
    check("r0_val", sv(0), 0);
    check("r0_busy", sb(0), 0);
    check("r0_tag", st(0), 0);

    // Asynchronous reset mid-stream
    rob_head = 4'd5;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b1; dh[k] = 1'b1; dd[k] = 4'(k + 1);
    end
    tick();
    clr_in();
    for (int p = 0; p < 4; p++) sidx[p] = 4'(p + 1);
    sidx[4] = 4'd5;
    #1;
    check("pre_rst_r4_busy", sb(3), 1);
    check("pre_rst_r4_tag", st(3), 8);
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("arst_busy_r%0d", p + 1), sb(p), 0);
    check("arst_r5_val", sv(4), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_r5_val", sv(4), 0);
    check("post_rst_r1_busy", sb(0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
